fetch_queue: RTL and testbench

Parametrised successor to the single-instruction fetch stage. It holds a fetch PC, reads the instruction ROM every cycle, and buffers {pc, instr} pairs in a DEPTH-entry FIFO. Decode pulls from the FIFO through a valid/ready handshake, so decode can stall without re-fetching. A branch redirect (PCSrc) flushes the FIFO and restarts fetch at the target. The block sits between the combinational rom and decode.

---
 rtl/fetch_if.sv | 12 +
 rtl/fetch_queue.sv | 73 +++++++
 tb/tb_fetch_queue.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Decode-side handshake between the fetch queue (master) and decode (slave).
interface fetch_if #(
  parameter int XLEN = 32
);
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (output out_valid, output out_pc, output out_instr, input out_ready);
  modport slave  (input out_valid, input out_pc, input out_instr, output out_ready);
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage with a DEPTH-entry {pc, instr} FIFO in front of decode; a redirect
// flushes the FIFO and restarts fetch at the word-aligned branch target.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [XLEN-1:0]            rom_address,
  input  logic [XLEN-1:0]            rom_data,
  input  logic                       PCSrc,
  input  logic [XLEN-1:0]            in_BranchTarget,
  fetch_if.master                    dq,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]   fpc_reg;
  logic [2*XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr_reg;
  logic [PW-1:0]     wr_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              valid;
  logic              pop;
  logic              push;

  // Masking valid during a redirect keeps stale entries away from decode.
  assign valid = (count_reg != '0) && !PCSrc;
  assign pop   = valid && dq.out_ready;
  assign push  = !PCSrc && ((count_reg < CW'(DEPTH)) || pop);

  assign rom_address  = fpc_reg;
  assign count        = count_reg;
  assign dq.out_valid = valid;
  assign dq.out_pc    = mem[rd_ptr_reg][2*XLEN-1:XLEN];
  assign dq.out_instr = mem[rd_ptr_reg][XLEN-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_reg    <= RESET_PC;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (PCSrc) begin
      fpc_reg    <= {in_BranchTarget[XLEN-1:2], 2'b00};
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        fpc_reg    <= fpc_reg + XLEN'(4);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is deliberately left out of reset so it can map to plain memory.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {fpc_reg, rom_data};
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: expected {pc, instr} pairs are queued as
// stimulus is applied and compared when decode accepts them.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rom_address;
  logic [31:0] rom_data;
  logic        PCSrc;
  logic [31:0] in_BranchTarget;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  fetch_if #(.XLEN(32)) dq ();

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .rom_address     (rom_address),
    .rom_data        (rom_data),
    .PCSrc           (PCSrc),
    .in_BranchTarget (in_BranchTarget),
    .dq              (dq),
    .count           (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h1234};
  endfunction

  assign rom_data = rom_word(rom_address);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    int exp_cnt;
    reset = 1'b1; PCSrc = 1'b0; in_BranchTarget = '0; dq.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (dq.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dq.out_valid); end
    checks++; if (rom_address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", rom_address); end
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_cnt = (k < 4) ? k : 4;
      checks++;
      if (count !== 3'(exp_cnt)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", k, count, exp_cnt); end
    end
    for (int k = 0; k < 2; k++) begin
      checks++; if (rom_address !== 32'h10) begin errors++; $display("FAIL full_addr: got %h expected 00000010", rom_address); end
      checks++; if (dq.out_pc !== 32'h0) begin errors++; $display("FAIL full_head_pc: got %h expected 00000000", dq.out_pc); end
      checks++; if (dq.out_instr !== rom_word(32'h0)) begin errors++; $display("FAIL full_head_instr: got %h expected %h", dq.out_instr, rom_word(32'h0)); end
      checks++; if (dq.out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b expected 1", dq.out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_stream_full();
    logic [31:0] e;
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
    dq.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      checks++; if (dq.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, dq.out_valid); end
      checks++; if (dq.out_pc !== e) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, dq.out_pc, e); end
      checks++; if (dq.out_instr !== rom_word(e)) begin errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, dq.out_instr, rom_word(e)); end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL stream_count[%0d]: got %0d expected 4", i, count); end
      $display("stream accept pc=%h instr=%h count=%0d", dq.out_pc, dq.out_instr, count);
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] e;
    int cyc, first;
    PCSrc = 1'b1; in_BranchTarget = 32'h40;
    #1;
    checks++; if (dq.out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_pulse: got %b expected 0", dq.out_valid); end
    @(negedge clk);
    PCSrc = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL redir_flush_count: got %0d expected 0", count); end
    exp_q.delete();
    exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48);
    cyc = 0; first = -1;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (dq.out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        e = exp_q.pop_front();
        checks++; if (dq.out_pc !== e) begin errors++; $display("FAIL redir_pc: got %h expected %h", dq.out_pc, e); end
        checks++; if (dq.out_instr !== rom_word(e)) begin errors++; $display("FAIL redir_instr: got %h expected %h", dq.out_instr, rom_word(e)); end
        $display("redirect accept pc=%h instr=%h", dq.out_pc, dq.out_instr);
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL redir_timeout: got %0d left expected 0", exp_q.size()); end
    checks++; if (first != 1) begin errors++; $display("FAIL redir_latency: got %0d expected 1", first); end
  endtask

  task automatic test_misaligned();
    logic [31:0] e;
    int cyc;
    PCSrc = 1'b1; in_BranchTarget = 32'h43;
    @(negedge clk);
    PCSrc = 1'b0;
    checks++; if (rom_address !== 32'h40) begin errors++; $display("FAIL misalign_addr: got %h expected 00000040", rom_address); end
    exp_q.delete();
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (dq.out_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++; if (dq.out_pc !== e) begin errors++; $display("FAIL misalign_pc: got %h expected %h", dq.out_pc, e); end
        $display("misaligned accept pc=%h instr=%h", dq.out_pc, dq.out_instr);
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL misalign_timeout: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    int cyc;
    dq.out_ready = 1'b0;
    PCSrc = 1'b1; in_BranchTarget = 32'h100;
    @(negedge clk);
    PCSrc = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_reset_count: got %0d expected 3", count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL async_reset_count: got %0d expected 0", count); end
    checks++; if (dq.out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", dq.out_valid); end
    checks++; if (rom_address !== 32'h0) begin errors++; $display("FAIL async_reset_addr: got %h expected 00000000", rom_address); end
    @(negedge clk);
    reset = 1'b0;
    dq.out_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (dq.out_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++; if (dq.out_pc !== e) begin errors++; $display("FAIL post_reset_pc: got %h expected %h", dq.out_pc, e); end
        $display("post-reset accept pc=%h instr=%h", dq.out_pc, dq.out_instr);
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL post_reset_timeout: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    int cyc;
    dq.out_ready = 1'b1;
    PCSrc = 1'b1; in_BranchTarget = 32'h80;
    @(negedge clk);
    in_BranchTarget = 32'hC0;
    #1;
    checks++; if (dq.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid: got %b expected 0", dq.out_valid); end
    @(negedge clk);
    PCSrc = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(32'hC0 + 32'(i * 4));
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (dq.out_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++; if (dq.out_pc !== e) begin errors++; $display("FAIL b2b_pc: got %h expected %h", dq.out_pc, e); end
        checks++; if (dq.out_instr !== rom_word(e)) begin errors++; $display("FAIL b2b_instr: got %h expected %h", dq.out_instr, rom_word(e)); end
        $display("back-to-back accept pc=%h instr=%h", dq.out_pc, dq.out_instr);
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_timeout: got %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_stream_full();
    test_redirect();
    test_misaligned();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
